// File: rtl/uart_tx_frm.sv
// UART transmit framer: start, LSB-first data, optional parity, stop bit(s).
// Define UART_TX_TWO_STOP_EN for two stop bits (default is one).
module uart_tx_frm #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_data_valid,
    input  logic [DATA_WIDTH-1:0] i_p_data,
    input  logic                  i_par_en,
    input  logic                  i_par_typ,
    output logic                  o_tx_out,
    output logic                  o_busy,
    output logic                  o_done
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(DATA_WIDTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t                r_state, w_state;
    logic [CW-1:0]         r_cnt, w_cnt;
    logic [IW-1:0]         r_idx, w_idx;
    logic [DATA_WIDTH-1:0] r_data, w_data;
    logic                  r_par_en, w_par_en;
    logic                  r_par_bit, w_par_bit;
    logic                  r_tx, w_tx;
    logic                  r_busy, w_busy;
    logic                  r_done, w_done;
    logic                  w_bit_end;
    logic                  w_last_idx;
`ifdef UART_TX_TWO_STOP_EN
    logic                  r_stop2, w_stop2;
`endif

    assign w_bit_end  = (r_cnt == CW'(CLKS_PER_BIT - 1));
    assign w_last_idx = (r_idx == IW'(DATA_WIDTH - 1));

    always_comb begin
        w_state   = r_state;
        w_cnt     = r_cnt;
        w_idx     = r_idx;
        w_data    = r_data;
        w_par_en  = r_par_en;
        w_par_bit = r_par_bit;
        w_tx      = r_tx;
        w_busy    = r_busy;
        w_done    = 1'b0;
`ifdef UART_TX_TWO_STOP_EN
        w_stop2   = r_stop2;
`endif
        if (r_state != S_IDLE) begin
            w_cnt = w_bit_end ? '0 : r_cnt + CW'(1);
        end
        unique case (r_state)
            S_IDLE: begin
                w_tx   = 1'b1;
                w_busy = 1'b0;
                if (i_data_valid) begin
                    w_state   = S_START;
                    w_cnt     = '0;
                    w_idx     = '0;
                    w_data    = i_p_data;
                    w_par_en  = i_par_en;
                    // odd parity is the inverse of the data XOR
                    w_par_bit = (^i_p_data) ^ i_par_typ;
                    w_tx      = 1'b0;
                    w_busy    = 1'b1;
                end
            end
            S_START: begin
                if (w_bit_end) begin
                    w_state = S_DATA;
                    w_tx    = r_data[0];
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    if (!w_last_idx) begin
                        w_idx = r_idx + IW'(1);
                        w_tx  = r_data[r_idx + IW'(1)];
                    end else if (r_par_en) begin
                        w_state = S_PARITY;
                        w_tx    = r_par_bit;
                    end else begin
                        w_state = S_STOP;
                        w_tx    = 1'b1;
                    end
                end
            end
            S_PARITY: begin
                if (w_bit_end) begin
                    w_state = S_STOP;
                    w_tx    = 1'b1;
                end
            end
            S_STOP: begin
                if (w_bit_end) begin
`ifdef UART_TX_TWO_STOP_EN
                    if (!r_stop2) begin
                        w_stop2 = 1'b1;
                    end else begin
                        w_stop2 = 1'b0;
                        w_state = S_IDLE;
                        w_busy  = 1'b0;
                        w_done  = 1'b1;
                    end
`else
                    w_state = S_IDLE;
                    w_busy  = 1'b0;
                    w_done  = 1'b1;
`endif
                end
            end
            default: begin
                w_state = S_IDLE;
                w_tx    = 1'b1;
                w_busy  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_idx     <= '0;
            r_data    <= '0;
            r_par_en  <= 1'b0;
            r_par_bit <= 1'b0;
            r_tx      <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
`ifdef UART_TX_TWO_STOP_EN
            r_stop2   <= 1'b0;
`endif
        end else begin
            r_state   <= w_state;
            r_cnt     <= w_cnt;
            r_idx     <= w_idx;
            r_data    <= w_data;
            r_par_en  <= w_par_en;
            r_par_bit <= w_par_bit;
            r_tx      <= w_tx;
            r_busy    <= w_busy;
            r_done    <= w_done;
`ifdef UART_TX_TWO_STOP_EN
            r_stop2   <= w_stop2;
`endif
        end
    end

    assign o_tx_out = r_tx;
    assign o_busy   = r_busy;
    assign o_done   = r_done;

endmodule
